// File: rtl/hazard3_tick_gen.sv
// Machine-timer tick generator: a programmable prescaler or a synchronised external
// NRZ tick drives a registered single-cycle strobe. The block is configured over APB.
module hazard3_tick_gen #(
  parameter int unsigned      W_DIV       = 16,
  parameter logic [W_DIV-1:0] DIV_RESET   = 16'd12,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        dbg_halt,
  input  logic        ext_tick_nrz,
  output logic        tick
);

  localparam logic [15:0] ADDR_CTRL    = 16'h0000;
  localparam logic [15:0] ADDR_DIV     = 16'h0004;
  localparam logic [15:0] ADDR_COUNT   = 16'h0008;
  localparam logic [15:0] ADDR_TICKCNT = 16'h000c;

  logic                   ctrl_en;
  logic                   ctrl_src;
  logic                   ctrl_dbg_freeze;
  logic [W_DIV-1:0]       div;
  logic [W_DIV-1:0]       ctr;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [31:0]            tickcnt;

  logic                   bus_wr;
  logic                   wr_ctrl;
  logic                   wr_div;
  logic                   wr_tickcnt;
  logic                   reload;
  logic [W_DIV-1:0]       div_new;
  logic                   frozen;
  logic                   active_pre;
  logic                   active_ext;
  logic                   ext_edge;
  logic                   ctr_expired;
  logic                   tick_next;
  logic                   unused_pwdata;

  assign pready        = 1'b1;
  assign pslverr       = 1'b0;
  assign unused_pwdata = ^pwdata;

  assign bus_wr     = psel && penable && pwrite;
  assign wr_ctrl    = bus_wr && (paddr == ADDR_CTRL);
  assign wr_div     = bus_wr && (paddr == ADDR_DIV);
  assign wr_tickcnt = bus_wr && (paddr == ADDR_TICKCNT);

  // Reload uses the post-write divisor, so a DIV write takes effect on the same cycle.
  assign reload  = wr_ctrl || wr_div;
  assign div_new = wr_div ? pwdata[W_DIV-1:0] : div;

  assign frozen      = ctrl_dbg_freeze && dbg_halt;
  assign active_pre  = ctrl_en && !ctrl_src && !frozen;
  assign active_ext  = ctrl_en && ctrl_src && !frozen;
  assign ext_edge    = sync[SYNC_STAGES-1] ^ prev;
  assign ctr_expired = ctr <= W_DIV'(1);

  always_comb begin
    tick_next = 1'b0;
    if (!reload) begin
      if (active_pre)
        tick_next = ctr_expired;
      else if (active_ext)
        tick_next = ext_edge;
    end
  end

  always_comb begin
    prdata = '0;
    case (paddr)
      ADDR_CTRL:    prdata = {29'd0, ctrl_dbg_freeze, ctrl_src, ctrl_en};
      ADDR_DIV:     prdata = 32'(div);
      ADDR_COUNT:   prdata = 32'(ctr);
      ADDR_TICKCNT: prdata = tickcnt;
      default:      prdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en         <= 1'b1;
      ctrl_src        <= 1'b0;
      ctrl_dbg_freeze <= 1'b1;
      div             <= DIV_RESET;
    end else begin
      if (wr_ctrl) begin
        ctrl_en         <= pwdata[0];
        ctrl_src        <= pwdata[1];
        ctrl_dbg_freeze <= pwdata[2];
      end
      if (wr_div)
        div <= pwdata[W_DIV-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= DIV_RESET;
    end else if (reload) begin
      ctr <= div_new;
    end else if (active_pre) begin
      ctr <= ctr_expired ? div : ctr - W_DIV'(1);
    end
  end

  // prev tracks the synchroniser output unconditionally so enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ext_tick_nrz};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= 1'b0;
      tickcnt <= '0;
    end else begin
      tick <= tick_next;
      if (wr_tickcnt)
        tickcnt <= '0;
      else if (tick)
        tickcnt <= tickcnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Directed bench for hazard3_tick_gen: register-access vector table plus hand-written
// sequences for prescaler period, debug freeze, external ticks, counter wrap and reset.
module tb_hazard3_tick_gen;

  logic        clk;
  logic        rst_n;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        dbg_halt;
  logic        ext_tick_nrz;
  logic        tick;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  hazard3_tick_gen #(
    .W_DIV(16),
    .DIV_RESET(16'd12),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .dbg_halt(dbg_halt),
    .ext_tick_nrz(ext_tick_nrz),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write commits on the following posedge.
  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
    paddr = addr; pwdata = data; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [15:0] addr, input logic [31:0] exp);
    paddr = addr; psel = 1'b1; pwrite = 1'b0; penable = 1'b0;
    #1;
    check(name, prdata, exp);
    psel = 1'b0;
  endtask

  task automatic chk_tick(input string name, input bit exp);
    check(name, {31'd0, tick}, {31'd0, exp});
  endtask

  task automatic add(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_vec(input int i);
    if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
    else chk_reg($sformatf("vec%0d_rd_%02h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
  endtask

  initial begin
    rst_n = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; dbg_halt = 1'b0; ext_tick_nrz = 1'b0;

    // Reset values (entries 0..4), then register behaviour with the block mostly disabled.
    add(0, 16'h00, 0, 32'h5);
    add(0, 16'h04, 0, 32'hc);
    add(0, 16'h08, 0, 32'hc);
    add(0, 16'h0c, 0, 32'h0);
    add(0, 16'h10, 0, 32'h0);
    add(1, 16'h00, 32'h0, 0);
    add(0, 16'h00, 0, 32'h0);
    add(0, 16'h0c, 0, 32'h3);
    add(1, 16'h04, 32'h1234, 0);
    add(0, 16'h04, 0, 32'h1234);
    add(0, 16'h08, 0, 32'h1234);
    add(1, 16'h00, 32'hffff_fff8, 0);
    add(0, 16'h00, 0, 32'h0);
    add(1, 16'h04, 32'habcd_0007, 0);
    add(0, 16'h04, 0, 32'h7);
    add(0, 16'h08, 0, 32'h7);
    add(1, 16'h10, 32'hffff_ffff, 0);
    add(0, 16'h10, 0, 32'h0);
    add(0, 16'h04, 0, 32'h7);
    add(0, 16'h00, 0, 32'h0);
    add(1, 16'h0c, 32'h55, 0);
    add(0, 16'h0c, 0, 32'h0);
    add(1, 16'h00, 32'h7, 0);
    add(0, 16'h00, 0, 32'h7);
    add(0, 16'h08, 0, 32'h7);
    add(1, 16'h00, 32'h5, 0);
    add(0, 16'h00, 0, 32'h5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_tick("reset_tick", 1'b0);
    check("pready", {31'd0, pready}, 32'd1);
    check("pslverr", {31'd0, pslverr}, 32'd0);
    for (int i = 0; i < 5; i++) run_vec(i);

    // Default divisor 12: ticks after edges 12, 24, 36.
    for (int k = 1; k <= 37; k++) begin
      step(1);
      chk_tick($sformatf("div12_k%0d", k), (k % 12) == 0);
    end
    chk_reg("tickcnt_after_3", 16'h0c, 32'd3);

    for (int i = 5; i < tbl.size(); i++) run_vec(i);

    // DIV = 3
    apb_write(16'h04, 32'd3);
    chk_reg("count_after_div3", 16'h08, 32'd3);
    chk_tick("div3_write_cycle", 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk_tick($sformatf("div3_k%0d", k), (k % 3) == 0);
    end

    // DIV = 0 -> tick every cycle
    apb_write(16'h04, 32'd0);
    chk_tick("div0_write_cycle", 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk_tick($sformatf("div0_k%0d", k), 1'b1);
    end

    // Debug freeze with DIV = 4
    apb_write(16'h04, 32'd4);
    apb_write(16'h00, 32'h5);
    step(2);
    chk_reg("frz_count_pre", 16'h08, 32'd2);
    dbg_halt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk_tick($sformatf("frz_halt_k%0d", k), 1'b0);
    end
    chk_reg("frz_count_held", 16'h08, 32'd2);
    dbg_halt = 1'b0;
    step(1);
    chk_tick("frz_resume1", 1'b0);
    chk_reg("frz_count_resume1", 16'h08, 32'd1);
    step(1);
    chk_tick("frz_resume2", 1'b1);
    chk_reg("frz_count_reload", 16'h08, 32'd4);

    // Same with DBG_FREEZE clear: halt is ignored
    apb_write(16'h00, 32'h1);
    step(2);
    dbg_halt = 1'b1;
    step(1);
    chk_tick("nofrz_k1", 1'b0);
    step(1);
    chk_tick("nofrz_k2", 1'b1);
    for (int k = 3; k <= 5; k++) begin
      step(1);
      chk_tick($sformatf("nofrz_k%0d", k), 1'b0);
    end
    step(1);
    chk_tick("nofrz_k6", 1'b1);
    dbg_halt = 1'b0;

    // External source: 5 toggles at 7-cycle spacing, tick 3 cycles after each
    apb_write(16'h00, 32'h3);
    apb_write(16'h0c, 32'h0);
    for (int t = 0; t < 5; t++) begin
      ext_tick_nrz = ~ext_tick_nrz;
      for (int k = 1; k <= 4; k++) begin
        step(1);
        chk_tick($sformatf("ext_t%0d_k%0d", t, k), k == 3);
      end
      step(3);
    end
    chk_reg("ext_tickcnt5", 16'h0c, 32'd5);

    // Toggles while disabled are dropped; no tick on re-enable
    apb_write(16'h00, 32'h2);
    for (int t = 0; t < 2; t++) begin
      ext_tick_nrz = ~ext_tick_nrz;
      for (int k = 1; k <= 7; k++) begin
        step(1);
        chk_tick($sformatf("ext_dis_t%0d_k%0d", t, k), 1'b0);
      end
    end
    apb_write(16'h00, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk_tick($sformatf("ext_reen_k%0d", k), 1'b0);
    end
    chk_reg("ext_tickcnt_hold", 16'h0c, 32'd5);

    // TICKCNT wrap from a preloaded all-ones value
    force dut.tickcnt = 32'hffff_ffff;
    ext_tick_nrz = ~ext_tick_nrz;
    step(2);
    release dut.tickcnt;
    step(1);
    chk_tick("wrap_tick", 1'b1);
    chk_reg("wrap_pre", 16'h0c, 32'hffff_ffff);
    step(1);
    chk_reg("wrap_post", 16'h0c, 32'h0);
    step(3);
    ext_tick_nrz = ~ext_tick_nrz;
    step(4);
    chk_reg("tickcnt_one", 16'h0c, 32'd1);

    // Clear write on the same cycle as an increment wins
    ext_tick_nrz = ~ext_tick_nrz;
    step(3);
    chk_tick("clr_race_tick", 1'b1);
    apb_write(16'h0c, 32'h1234_5678);
    chk_reg("clr_race_cnt", 16'h0c, 32'h0);

    // Asynchronous reset mid-operation with DIV = 5
    apb_write(16'h04, 32'd5);
    apb_write(16'h00, 32'h1);
    step(4);
    chk_tick("div5_pre", 1'b0);
    step(1);
    chk_tick("div5_tick", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_tick("async_rst_tick", 1'b0);
    chk_reg("rst_ctrl", 16'h00, 32'h5);
    chk_reg("rst_div", 16'h04, 32'hc);
    chk_reg("rst_tickcnt", 16'h0c, 32'h0);
    chk_reg("rst_count", 16'h08, 32'hc);
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard3_tick_gen.md
Name: hazard3_tick_gen

Overview:
- Timebase generator that produces the single-cycle `tick` strobe consumed by the RISC-V machine timer. The timer's `mtime` increments once per strobe.
- Two strobe sources:
  - an internal programmable prescaler clocked by `clk`;
  - a synchronised, edge-detected external NRZ tick input.
- Configured over the same 32-bit APB peripheral bus as the timer.
- Sits between the SoC clock/reference-tick source and the timer's `tick` input.

Parameters:
- W_DIV, 16: width of the prescaler divisor and counter.
- DIV_RESET, 16'd12: divisor loaded at reset.
- SYNC_STAGES, 2: synchroniser flop count on `ext_tick_nrz` (minimum 2).

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- paddr, input, 16: APB address.
- psel, input, 1: APB select.
- penable, input, 1: APB enable.
- pwrite, input, 1: APB write.
- pwdata, input, 32: APB write data.
- prdata, output, 32: APB read data (combinational).
- pready, output, 1: tied to 1.
- pslverr, output, 1: tied to 0.
- dbg_halt, input, 1: any hart halted in debug mode.
- ext_tick_nrz, input, 1: external tick. Asynchronous to `clk`; each transition is one tick.
- tick, output, 1: registered single-cycle tick strobe to the timer.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low. All flops reset on `rst_n` low.
- Bus write strobe: `psel && penable && pwrite`. Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- Register map:
  - 0x00 CTRL, RW.
    - bit0 EN, reset 1.
    - bit1 SRC, reset 0. 0 = prescaler, 1 = external.
    - bit2 DBG_FREEZE, reset 1.
    - Other bits read 0.
  - 0x04 DIV, RW, bits [W_DIV-1:0]. Reset DIV_RESET. Upper bits read 0.
  - 0x08 COUNT, RO. Current prescaler counter, zero-extended.
  - 0x0C TICKCNT, RW. 32-bit count of emitted ticks. Any write clears it to 0; the write data is ignored.
- Frozen condition: `frozen = DBG_FREEZE && dbg_halt`.
  - `active_pre = EN && !SRC && !frozen`.
  - `active_ext = EN && SRC && !frozen`.
- Prescaler:
  - `ctr` resets to DIV_RESET.
  - When `active_pre` and `ctr <= 1`: `ctr <= DIV` and tick_next = 1.
  - Otherwise, when `active_pre`: `ctr <= ctr - 1` and tick_next = 0.
  - When not `active_pre`: `ctr` holds.
  - Period is DIV cycles for DIV >= 1. DIV = 0 behaves as DIV = 1, i.e. a tick every cycle.
- Reload rule: any write to CTRL or to DIV sets `ctr <= new DIV` (the post-write value) on that cycle, overriding decrement and reload. No tick is produced that cycle.
- External path:
  - `ext_tick_nrz` passes through a SYNC_STAGES-flop synchroniser, all flops reset 0, then one history flop `prev`.
  - `edge = sync_out ^ prev`.
  - tick_next = `edge && active_ext`.
  - Edges that occur while not `active_ext` are dropped, not queued.
  - `prev` updates every cycle regardless of EN, SRC or freeze, so no spurious tick appears on enable or unfreeze.
  - Latency from an input transition to `tick` high: SYNC_STAGES+1 `clk` cycles. A 2-flop synchroniser gives 3 cycles, plus up to 1 cycle of sampling uncertainty.
- tick:
  - Registered from tick_next; reset 0.
  - High for exactly one cycle per event.
  - Never high while EN = 0, or in the cycle after a `frozen` cycle that suppressed an event.
- TICKCNT:
  - Increments when `tick == 1`; wraps 0xFFFFFFFF -> 0.
  - A write on the same cycle as an increment wins: result is 0.
- Switching SRC mid-count: the prescaler state holds while SRC = 1 and resumes from the held `ctr` only after the CTRL-write reload, i.e. from DIV.
- Reset asserted mid-operation: `tick` drops immediately (asynchronously). Registers return to reset values.

Test Plan:
- Reset, no writes -> first `tick` 12 cycles after reset release, then every 12 cycles; TICKCNT reads 3 after 36 cycles.
- Write DIV = 3 -> COUNT reads 3 the next cycle; ticks every 3 cycles. Write DIV = 0 -> `tick` high every cycle.
- Write CTRL = 0x5 with SRC = 0 and DIV = 4, then assert `dbg_halt` for 10 cycles -> no tick and COUNT frozen during halt; counting resumes from the held value. Repeat with CTRL = 0x1 -> halt has no effect.
- Write CTRL = 0x3, then toggle `ext_tick_nrz` 5 times at 7-cycle spacing -> 5 ticks, each 3 cycles after its transition; TICKCNT = 5. Toggles made while EN = 0 -> no ticks, and no tick on re-enable.
- Write TICKCNT = 0xFFFFFFFF via test preload, or count up to it -> next tick wraps it to 0. Write TICKCNT on the same cycle as a tick -> reads 0.
- Assert `rst_n` low mid-period with DIV = 5 -> `tick` is 0 immediately; CTRL reads 0x5, DIV reads 12, TICKCNT reads 0.
